// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: command stage driving a JK flip-flop bank and checking its Q feedback
module jk_excitation_driver #(
  parameter int WIDTH    = 4,
  parameter int COUNT_W  = 4,
  parameter int ERRCNT_W = 8
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Cmd_Valid,
  output logic                Cmd_Ready,
  input  logic [1:0]          Cmd_Op,
  input  logic [WIDTH-1:0]    Cmd_Mask,
  input  logic [COUNT_W-1:0]  Cmd_Count,
  input  logic [WIDTH-1:0]    Q_fb,
  output logic [WIDTH-1:0]    J,
  output logic [WIDTH-1:0]    K,
  output logic                Busy,
  output logic [WIDTH-1:0]    Expected,
  output logic                Done,
  output logic                Err,
  output logic [ERRCNT_W-1:0] Err_Cnt
);
  typedef enum logic [1:0] {INIT, IDLE, DRIVE, CHECK} state_t;
  state_t state, state_nx;
  logic [COUNT_W-1:0] cnt;
  logic [WIDTH-1:0] exp_nx;
  logic accept, mismatch;
  // INIT keeps Cmd_Ready low during reset and for the first cycle after release
  assign Cmd_Ready = state == IDLE;
  assign Busy      = state == DRIVE || state == CHECK;
  assign accept    = Cmd_Valid && Cmd_Ready;
  assign mismatch  = Q_fb != Expected;
  always_comb begin
    state_nx = state == INIT  ? IDLE :
               state == IDLE  ? (Cmd_Valid ? DRIVE : IDLE) :
               state == DRIVE ? (cnt == '0 ? CHECK : DRIVE) : IDLE;
    exp_nx   = Cmd_Op == 2'b00 ? Q_fb :
               Cmd_Op == 2'b01 ? Q_fb & ~Cmd_Mask :
               Cmd_Op == 2'b10 ? Q_fb | Cmd_Mask :
               Q_fb ^ (Cmd_Mask & {WIDTH{~Cmd_Count[0]}});
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= INIT;
    else state <= state_nx;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      cnt      <= '0;
      J        <= '0;
      K        <= '0;
      Expected <= '0;
      Done     <= 1'b0;
      Err      <= 1'b0;
      Err_Cnt  <= '0;
    end else begin
      Done <= 1'b0;
      Err  <= 1'b0;
      if (accept) begin
        cnt      <= Cmd_Count;
        J        <= Cmd_Mask & {WIDTH{Cmd_Op[1]}};
        K        <= Cmd_Mask & {WIDTH{Cmd_Op[0]}};
        Expected <= exp_nx;
      end else if (state == DRIVE) begin
        if (cnt == '0) begin
          J <= '0;
          K <= '0;
        end else cnt <= cnt - 1'b1;
      end else if (state == CHECK) begin
        Done    <= 1'b1;
        Err     <= mismatch;
        Err_Cnt <= (mismatch && !(&Err_Cnt)) ? Err_Cnt + ERRCNT_W'(1) : Err_Cnt;
      end
    end
endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb_jk_excitation_driver: drives the command stage into a JK flop bank and scoreboards Done/Err
module tb_jk_excitation_driver;
  logic       Clk = 1'b0, Reset_n = 1'b1, Cmd_Valid = 1'b0;
  logic       Cmd_Ready, Busy, Done, Err;
  logic [1:0] Cmd_Op = '0;
  logic [3:0] Cmd_Mask = '0, Cmd_Count = '0, Q_fb, J, K, Expected;
  logic [7:0] Err_Cnt;
  logic [3:0] q = 4'h0;
  logic       force_en = 1'b0;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [3:0] e; logic err; int due;} sb_t;
  sb_t sb[$];

  jk_excitation_driver dut (
    .Clk(Clk), .Reset_n(Reset_n), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_Op(Cmd_Op), .Cmd_Mask(Cmd_Mask), .Cmd_Count(Cmd_Count), .Q_fb(Q_fb),
    .J(J), .K(K), .Busy(Busy), .Expected(Expected), .Done(Done), .Err(Err), .Err_Cnt(Err_Cnt)
  );

  always #5 Clk = ~Clk;
  // JK flop bank, never reset
  always @(posedge Clk) q <= (J & ~q) | (~K & q);
  assign Q_fb = force_en ? 4'hF : q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] predict(input logic [3:0] q0, input logic [1:0] op,
                                         input logic [3:0] m, input logic [3:0] c);
    logic [3:0] s = q0;
    for (int i = 0; i <= int'(c); i++)
      s = ((m & {4{op[1]}}) & ~s) | (~(m & {4{op[0]}}) & s);
    return s;
  endfunction

  always @(posedge Clk) begin
    sb_t t;
    cyc++;
    if (Reset_n && Cmd_Valid && Cmd_Ready) begin
      t.e   = predict(Q_fb, Cmd_Op, Cmd_Mask, Cmd_Count);
      t.err = force_en && (t.e != 4'hF);
      t.due = cyc + int'(Cmd_Count) + 2;
      sb.push_back(t);
    end
  end

  always @(negedge Reset_n) sb.delete();

  always @(negedge Clk) begin
    sb_t t;
    if (Reset_n && Done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        t = sb.pop_front();
        chk("sb_expected", Expected, t.e);
        chk("sb_err", Err, t.err);
        chk("sb_latency", cyc, t.due);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] m, input logic [3:0] c, input bit keep);
    Cmd_Op = op; Cmd_Mask = m; Cmd_Count = c; Cmd_Valid = 1'b1;
    for (int i = 0; i < 50 && !Cmd_Ready; i++) @(negedge Clk);
    chk("issue_ready", Cmd_Ready, 1);
    @(posedge Clk);
    @(negedge Clk);
    if (!keep) Cmd_Valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (Done) break;
    end
    chk("done_seen", Done, 1);
  endtask

  initial begin
    // 1: async reset mid-cycle
    #7 Reset_n = 1'b0;
    #1;
    chk("rst_j", J, 0); chk("rst_k", K, 0); chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0); chk("rst_err", Err, 0); chk("rst_errcnt", Err_Cnt, 0);
    chk("rst_ready", Cmd_Ready, 0); chk("rst_expected", Expected, 0);
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;
    chk("rel_ready_low", Cmd_Ready, 0);
    @(negedge Clk);
    chk("rel_ready_high", Cmd_Ready, 1);
    // 2: set 1010, single drive cycle
    issue(2'b10, 4'b1010, 4'd0, 0);
    chk("set_j", J, 4'b1010); chk("set_k", K, 4'b0000); chk("set_busy", Busy, 1);
    @(negedge Clk);
    chk("set_check_j", J, 0); chk("set_q", q, 4'b1010);
    wait_done();
    chk("set_err", Err, 0);
    // 3: toggle all three times, then twice
    issue(2'b11, 4'b1111, 4'd2, 0);
    for (int i = 0; i < 3; i++) begin
      chk("tog_j", J, 4'hF); chk("tog_k", K, 4'hF);
      @(negedge Clk);
    end
    chk("tog_check_j", J, 0);
    wait_done();
    chk("tog_q", q, 4'b0101); chk("tog_expected", Expected, 4'b0101);
    issue(2'b11, 4'b1111, 4'd1, 0);
    wait_done();
    chk("tog2_q", q, 4'b0101); chk("tog2_expected", Expected, 4'b0101);
    // 4: forced mismatch, counter saturation
    force_en = 1'b1;
    for (int r = 0; r < 257; r++) begin
      issue(2'b01, 4'b1111, 4'd0, 0);
      wait_done();
      if (r == 0) chk("errcnt_first", Err_Cnt, 1);
      if (r == 254) chk("errcnt_255", Err_Cnt, 255);
    end
    chk("errcnt_sat", Err_Cnt, 255);
    force_en = 1'b0;
    chk("rstop_q", q, 4'b0000);
    // 5: Valid held with new fields while busy
    issue(2'b11, 4'b0011, 4'd3, 1);
    Cmd_Op = 2'b10; Cmd_Mask = 4'b1100; Cmd_Count = 4'd0;
    for (int i = 0; i < 4; i++) begin
      chk("busy_j", J, 4'b0011); chk("busy_ready", Cmd_Ready, 0);
      @(negedge Clk);
    end
    wait_done();
    chk("done_ready", Cmd_Ready, 1);
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    chk("b2b_busy", Busy, 1); chk("b2b_j", J, 4'b1100); chk("b2b_k", K, 4'b0000);
    wait_done();
    chk("b2b_q", q, 4'b1100);
    // 6: reset during drive
    issue(2'b11, 4'b1111, 4'd7, 0);
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    chk("abort_j", J, 0); chk("abort_k", K, 0); chk("abort_busy", Busy, 0);
    chk("abort_ready", Cmd_Ready, 0); chk("abort_errcnt", Err_Cnt, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      chk("abort_no_done", Done, 0);
      if (i == 0) chk("abort_ready_after", Cmd_Ready, 1);
    end
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
